// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin arbiter in front of an 8:1 one-bit data mux.
// A two-state IDLE/GRANT machine picks a requester, registers its data bit and
// holds it until the downstream side accepts it. The requester just served
// then drops to the lowest priority.
module mux_rr_scheduler #(
    parameter int NREQ = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in,
    input  logic            out_ready,
    output logic [2:0]      sel,
    output logic            out_valid,
    output logic            out_data,
    output logic [NREQ-1:0] ack,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [2:0]      ptr_q;
    logic [2:0]      sel_q;
    logic            outData_q;
    logic            outValid_q;
    logic [NREQ-1:0] ack_q;

    logic [2:0]      winIdx_d;
    logic            winFound_d;
    logic [2:0]      cand;

    // Scan the requests starting at the priority pointer and take the first set bit.
    always_comb begin
        winIdx_d   = ptr_q;
        winFound_d = 1'b0;
        cand       = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + 3'(k);
            if (!winFound_d && req[cand]) begin
                winIdx_d   = cand;
                winFound_d = 1'b1;
            end
        end
    end

    // Arbitration FSM: capture the grant in IDLE, hold it in GRANT until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            sel_q      <= 3'd0;
            outData_q  <= 1'b0;
            outValid_q <= 1'b0;
            ack_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (winFound_d) begin
                        sel_q      <= winIdx_d;
                        outData_q  <= in[winIdx_d];
                        outValid_q <= 1'b1;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (outValid_q && out_ready) begin
                        ack_q      <= NREQ'(1) << sel_q;
                        outValid_q <= 1'b0;
                        ptr_q      <= sel_q + 3'd1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign ack       = ack_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 Parameter: NREQ, 8, number of requesters; fixed at 8 so the grant index matches a 3-bit select.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-requester request level; bit i = requester i wants service.
REQ-005 in  input  8  per-requester data bit; in[i] belongs to requester i.
REQ-006 out_ready  input  1  downstream ready for the granted bit.
REQ-007 sel  output  3  registered index of the current grant; drives the 8:1 select.
REQ-008 out_valid  output  1  registered; granted bit on out_data is valid.
REQ-009 out_data  output  1  registered copy of in[sel], captured at grant time.
REQ-010 ack  output  8  one-hot, one-cycle pulse on the accepted requester.
REQ-011 busy  output  1  high while state is GRANT.

Function
REQ-012 The block SHALL implement two states: IDLE and GRANT.
REQ-013 A 3-bit priority pointer ptr SHALL hold the highest-priority index for the next arbitration.
REQ-014 In IDLE with req == 0, state, sel, out_data, ptr SHALL hold; out_valid = 0.
REQ-015 In IDLE with req != 0, the winner SHALL be the first set bit of req scanning ptr, ptr+1, ..., ptr+7 modulo 8.
REQ-016 On that edge: sel <= winner, out_data <= in[winner], out_valid <= 1, state <= GRANT (latency one cycle from req to out_valid).
REQ-017 In GRANT, sel, out_data, out_valid SHALL stay stable until out_valid && out_ready.
REQ-018 Changes on in or req during GRANT SHALL NOT alter out_data or sel (no retraction).
REQ-019 On out_valid && out_ready: ack[sel] pulses for exactly the next cycle, out_valid <= 0, ptr <= sel + 1 modulo 8 (7 wraps to 0), state <= IDLE.
REQ-020 The block SHALL spend at least one cycle in IDLE between grants; max throughput one grant per two cycles.
REQ-021 A requester that keeps req high after its ack SHALL have lowest priority at the next arbitration.
REQ-022 out_ready while out_valid = 0 SHALL have no effect.
REQ-023 ack SHALL be all-zero except the single cycle after a completed handshake; at most one bit set.
REQ-024 busy SHALL equal (state == GRANT).

Reset
REQ-025 rst_n low SHALL immediately force state = IDLE, ptr = 0, sel = 0, out_valid = 0, out_data = 0, ack = 0, busy = 0, regardless of clk.
REQ-026 Reset mid-GRANT SHALL drop out_valid without an ack; the pending grant is lost.
REQ-027 After rst_n rises, the first arbitration SHALL occur on the first rising edge with req != 0.

Verification
REQ-028 Reset, req = 8'b0000_0000 for 5 cycles -> out_valid = 0, sel = 0, ack = 0 throughout.
REQ-029 req = 8'b0001_0000, in = 8'b0101_0101, out_ready = 1 -> next cycle sel = 4, out_data = 1, out_valid = 1; following cycle ack = 8'b0001_0000; ptr = 5.
REQ-030 req = 8'hFF held, out_ready = 1 -> grant order 0,1,2,...,7,0 with one grant every two cycles; wrap 7 -> 0 verified.
REQ-031 Backpressure: grant to index 2 with out_ready = 0 for 4 cycles while in and req toggle -> sel = 2, out_data unchanged, no ack until out_ready = 1.
REQ-032 ptr = 6, req = 8'b0100_0001 -> winner 6; after handshake, ptr = 7 and next winner 0.
REQ-033 Assert rst_n low mid-GRANT, asynchronous to clk -> out_valid, sel, out_data clear immediately, ack stays 0, state IDLE.
